// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU definitions: memory map, opcodes, ROM image, region decode
package cpu_defs;

  localparam logic [7:0] ROM_BASE = 8'h00;
  localparam logic [7:0] RAM_BASE = 8'h80;
  localparam logic [7:0] OUT_BASE = 8'hE0;
  localparam logic [7:0] IN_BASE  = 8'hF0;

  localparam int ROM_BYTES = 128;
  localparam int RAM_BYTES = 96;
  localparam int NUM_PORTS = 16;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDA = 8'h10;
  localparam logic [7:0] OP_LDB = 8'h20;
  localparam logic [7:0] OP_STA = 8'h30;
  localparam logic [7:0] OP_ADD = 8'h40;
  localparam logic [7:0] OP_SUB = 8'h50;
  localparam logic [7:0] OP_JMP = 8'h60;
  localparam logic [7:0] OP_JZ  = 8'h70;
  localparam logic [7:0] OP_IN  = 8'hA0;
  localparam logic [7:0] OP_OUT = 8'hB0;
  localparam logic [7:0] OP_HLT = 8'hFF;

  // Byte k of the image lives at bits [8k+7:8k]: LDA 0x5A, then a marker byte at 0x05.
  localparam logic [ROM_BYTES*8-1:0] DEFAULT_ROM_IMAGE =
    {976'h0, 8'h3E, 8'h00, 8'h00, 8'h00, 8'h5A, OP_LDA};

  typedef enum logic [1:0] {
    REG_ROM = 2'd0,
    REG_RAM = 2'd1,
    REG_OUT = 2'd2,
    REG_IN  = 2'd3
  } region_e;

  function automatic region_e decode_region(input logic [7:0] addr);
    if (addr < RAM_BASE)      return REG_ROM;
    else if (addr < OUT_BASE) return REG_RAM;
    else if (addr < IN_BASE)  return REG_OUT;
    else                      return REG_IN;
  endfunction

endpackage

// File: rtl/input_port_sync.sv
// rtl/input_port_sync.sv - 8-bit multi-flop synchronizer for one asynchronous input port
module input_port_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d_i,
  output logic [7:0] q_o
);

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [SYNC_STAGES-1:0][7:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/memory_system.sv
// rtl/memory_system.sv - CPU memory responder: ROM, RAM, 16 out ports, 16 synchronized in ports
module memory_system
  import cpu_defs::*;
#(
  parameter logic [ROM_BYTES*8-1:0] ROM_IMAGE   = DEFAULT_ROM_IMAGE,
  parameter int                     SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   address,
  input  logic [7:0]   data_in,
  input  logic         write,
  output logic [7:0]   data_out,
  input  logic [127:0] port_in,
  output logic [127:0] port_out,
  output logic         rom_wr_err
);

  region_e                     region;
  logic [6:0]                  ram_idx;
  logic [7:0]                  ram_q [RAM_BYTES];
  logic [NUM_PORTS-1:0][7:0]   port_out_q, port_out_d;
  logic [NUM_PORTS-1:0][7:0]   port_sync;
  logic [7:0]                  data_out_q, data_out_d;
  logic                        rom_wr_err_q, rom_wr_err_d;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_in_sync
    input_port_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .reset(reset),
      .d_i  (port_in[8*k +: 8]),
      .q_o  (port_sync[k])
    );
  end

  // RAM spans 0x80-0xDF, so the low seven address bits are already the RAM offset.
  assign ram_idx = address[6:0];

  always_comb begin
    region       = decode_region(address);
    data_out_d   = 8'h00;
    port_out_d   = port_out_q;
    rom_wr_err_d = rom_wr_err_q;

    case (region)
      REG_ROM: data_out_d = ROM_IMAGE[{address[6:0], 3'b000} +: 8];
      REG_RAM: data_out_d = ram_q[ram_idx];
      REG_OUT: data_out_d = port_out_q[address[3:0]];
      REG_IN:  data_out_d = port_sync[address[3:0]];
      default: data_out_d = 8'h00;
    endcase

    if (write) begin
      case (region)
        REG_OUT:        port_out_d[address[3:0]] = data_in;
        REG_ROM, REG_IN: rom_wr_err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q   <= 8'h00;
      port_out_q   <= '0;
      rom_wr_err_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      port_out_q   <= port_out_d;
      rom_wr_err_q <= rom_wr_err_d;
    end
  end

  // RAM contents survive reset; a write landing while reset is held is dropped.
  always_ff @(posedge clk) begin
    if (reset && write && (region == REG_RAM)) begin
      ram_q[ram_idx] <= data_in;
    end
  end

  assign data_out   = data_out_q;
  assign port_out   = port_out_q;
  assign rom_wr_err = rom_wr_err_q;

endmodule

// File: tb/tb_memory_system.sv
// tb/tb_memory_system.sv - directed self-checking bench for memory_system
module tb_memory_system;
  import cpu_defs::*;

  logic         clk;
  logic         reset;
  logic [7:0]   address;
  logic [7:0]   data_in;
  logic         write;
  logic [7:0]   data_out;
  logic [127:0] port_in;
  logic [127:0] port_out;
  logic         rom_wr_err;

  int passed;
  int total;

  memory_system #(
    .ROM_IMAGE  (DEFAULT_ROM_IMAGE),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .data_in   (data_in),
    .write     (write),
    .data_out  (data_out),
    .port_in   (port_in),
    .port_out  (port_out),
    .rom_wr_err(rom_wr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic wr, input logic [7:0] addr, input logic [7:0] din);
    write   = wr;
    address = addr;
    data_in = din;
  endtask

  localparam logic [127:0] PORTS_E3_EF = {8'h9C, 88'h0, 8'h77, 24'h0};

  initial begin
    passed  = 0;
    total   = 0;
    reset   = 1'b1;
    write   = 1'b0;
    address = 8'h00;
    data_in = 8'h00;
    port_in = '0;
    port_in[15:8] = 8'h5B;

    #1 reset = 1'b0;
    #1;
    check("reset_data_out", {120'h0, data_out}, 128'h0);
    check("reset_port_out", port_out, 128'h0);
    check("reset_err", {127'h0, rom_wr_err}, 128'h0);
    step();
    step();
    reset = 1'b1;

    // ROM reads, 1-cycle latency
    drive(1'b0, 8'h00, 8'h00); step();
    check("rom_00", {120'h0, data_out}, 128'h10);
    drive(1'b0, 8'h01, 8'h00); step();
    check("rom_01", {120'h0, data_out}, 128'h5A);
    drive(1'b0, 8'h7F, 8'h00); step();
    check("rom_7f", {120'h0, data_out}, 128'h00);

    // RAM writes back-to-back, readback, read-first
    drive(1'b1, 8'h80, 8'hA5); step();
    drive(1'b1, 8'hDF, 8'h3C); step();
    drive(1'b0, 8'h80, 8'h00); step();
    check("ram_80", {120'h0, data_out}, 128'hA5);
    drive(1'b0, 8'hDF, 8'h00); step();
    check("ram_df", {120'h0, data_out}, 128'h3C);
    drive(1'b1, 8'h80, 8'h11); step();
    check("ram_read_first", {120'h0, data_out}, 128'hA5);
    drive(1'b0, 8'h80, 8'h00); step();
    check("ram_80_new", {120'h0, data_out}, 128'h11);
    drive(1'b1, 8'h80, 8'hA5); step();
    check("ram_rewrite_old", {120'h0, data_out}, 128'h11);

    // Output ports
    drive(1'b1, 8'hE3, 8'h77); step();
    check("port3_only", port_out, {96'h0, 8'h77, 24'h0});
    drive(1'b1, 8'hEF, 8'h9C); step();
    check("port3_port15", port_out, PORTS_E3_EF);
    drive(1'b0, 8'hE3, 8'h00); step();
    check("port3_readback", {120'h0, data_out}, 128'h77);
    drive(1'b0, 8'hE0, 8'h00); step();
    check("port0_readback", {120'h0, data_out}, 128'h00);
    check("err_clear_before", {127'h0, rom_wr_err}, 128'h0);

    // Illegal writes to ROM and input space
    drive(1'b1, 8'h05, 8'hFF); step();
    check("err_rom_write", {127'h0, rom_wr_err}, 128'h1);
    drive(1'b1, 8'hF2, 8'hFF); step();
    check("err_in_write", {127'h0, rom_wr_err}, 128'h1);
    drive(1'b0, 8'h05, 8'h00); step();
    check("rom_05_kept", {120'h0, data_out}, 128'h3E);
    check("err_sticky", {127'h0, rom_wr_err}, 128'h1);
    drive(1'b0, 8'hF2, 8'h00); step();
    check("in_f2", {120'h0, data_out}, 128'h00);
    check("ports_kept", port_out, PORTS_E3_EF);

    // Input port synchronizer latency
    drive(1'b0, 8'hF1, 8'h00);
    port_in[15:8] = 8'hC3;
    step();
    check("sync_edge1", {120'h0, data_out}, 128'h5B);
    step();
    check("sync_edge2", {120'h0, data_out}, 128'h5B);
    step();
    check("sync_edge3", {120'h0, data_out}, 128'hC3);

    // Asynchronous reset mid-read
    drive(1'b0, 8'h80, 8'h00); step();
    check("ram_80_pre_reset", {120'h0, data_out}, 128'hA5);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_data_out", {120'h0, data_out}, 128'h0);
    check("async_port_out", port_out, 128'h0);
    check("async_err", {127'h0, rom_wr_err}, 128'h0);
    @(negedge clk);
    drive(1'b1, 8'h80, 8'hEE); step();
    check("reset_held_data_out", {120'h0, data_out}, 128'h0);
    reset = 1'b1;
    drive(1'b0, 8'h80, 8'h00); step();
    check("ram_80_post_reset", {120'h0, data_out}, 128'hA5);
    drive(1'b0, 8'h00, 8'h00); step();
    check("rom_00_post_reset", {120'h0, data_out}, 128'h10);
    check("port_out_post_reset", port_out, 128'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
